// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder slice stepped LSB to MSB over WIDTH cycles,
// with a start/done handshake and registered sum, carry-out and signed overflow.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   input  logic             done_ack,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic [1:0]       state_dbg
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_PRE  = CW'(WIDTH - 2);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Handshake: start is taken only on an edge where ready=1; the result on
   // sum/cout/ovf is valid while done=1 and is released by done_ack on an edge.
   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-2:0] sum_sh;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             cmsb;

   logic             s_bit;
   logic             c_bit;
   logic [WIDTH-1:0] sum_next;

   always_comb begin
      s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
      c_bit    = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
      sum_next = {s_bit, sum_sh};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         cmsb   <= 1'b0;
         sum    <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= cin;
                  cnt   <= '0;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               // sum_sh holds only the upper WIDTH-1 bits; the newest bit joins at the final step
               sum_sh <= sum_next[WIDTH-1:1];
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               carry  <= c_bit;
               if (cnt == CNT_PRE)
                  cmsb <= c_bit;
               if (cnt == CNT_LAST) begin
                  sum   <= sum_next;
                  cout  <= c_bit;
                  ovf   <= cmsb ^ c_bit;
                  state <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (done_ack)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign ready     = (state == S_IDLE);
   assign busy      = (state == S_RUN);
   assign done      = (state == S_DONE);
   assign state_dbg = state;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed handshake/boundary scenarios
// plus randomized additions compared with an arithmetic reference model.
module tb_serial_add_ctrl;

   localparam int W = 8;
   localparam int LIMIT = 4 * W;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a_i;
   logic [W-1:0] b_i;
   logic         cin_i;
   logic         ready;
   logic         busy;
   logic         done;
   logic         done_ack;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic [1:0]   state_dbg;

   int n_checks = 0;
   int n_fail   = 0;
   logic [W+1:0] exp_q[$];

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (a_i),
      .b        (b_i),
      .cin      (cin_i),
      .ready    (ready),
      .busy     (busy),
      .done     (done),
      .done_ack (done_ack),
      .sum      (sum),
      .cout     (cout),
      .ovf      (ovf),
      .state_dbg(state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: plain integer addition, overflow from operand/result signs
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic c);
      logic [W:0] full;
      logic       v;
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      v    = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
      return {v, full[W], full[W-1:0]};
   endfunction

   // driver: issue one addition from IDLE, count busy cycles, capture the result,
   // wait ack_delay cycles, acknowledge. All driving/sampling on the falling edge.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input int ack_delay, output int cyc, output logic [W+1:0] res,
                         output logic done_seen, output logic ready_after);
      a_i   = a;
      b_i   = b;
      cin_i = c;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a_i   = W'($urandom);
      b_i   = W'($urandom);
      cin_i = 1'($urandom);
      cyc = 0;
      while (busy && cyc < LIMIT) begin
         cyc++;
         @(negedge clk);
      end
      done_seen = done;
      res = {ovf, cout, sum};
      repeat (ack_delay) @(negedge clk);
      done_ack = 1'b1;
      @(negedge clk);
      done_ack = 1'b0;
      ready_after = ready && !done;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_checks += 6;
      if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
      if (sum !== '0) begin n_fail++; $display("FAIL reset_sum got %h want 00", sum); end
      if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got %b want 0", cout); end
      if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_idle got ready=%b busy=%b want 1/0", ready, busy);
      end
   endtask

   task automatic test_basic_add;
      int         cyc;
      logic [W+1:0] res;
      logic       ds, ra;
      run_op(8'h3C, 8'h42, 1'b0, 2, cyc, res, ds, ra);
      n_checks += 4;
      if (cyc !== W) begin n_fail++; $display("FAIL basic_latency got %0d want %0d", cyc, W); end
      if (ds !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b want 1", ds); end
      if (res !== {1'b0, 1'b0, 8'h7E}) begin
         n_fail++; $display("FAIL basic_result got %h want %h", res, {2'b00, 8'h7E});
      end
      if (ra !== 1'b1) begin n_fail++; $display("FAIL basic_ready_after_ack got %b want 1", ra); end
   endtask

   task automatic test_boundaries;
      logic [W-1:0] va[3];
      logic [W-1:0] vb[3];
      logic         vc[3];
      logic [W+1:0] vexp[3];
      int           cyc;
      logic [W+1:0] res;
      logic         ds, ra;
      va[0] = 8'hFF; vb[0] = 8'h01; vc[0] = 1'b0; vexp[0] = {1'b0, 1'b1, 8'h00};
      va[1] = 8'h7F; vb[1] = 8'h01; vc[1] = 1'b0; vexp[1] = {1'b1, 1'b0, 8'h80};
      va[2] = 8'h80; vb[2] = 8'h80; vc[2] = 1'b1; vexp[2] = {1'b1, 1'b1, 8'h01};
      for (int i = 0; i < 3; i++) begin
         run_op(va[i], vb[i], vc[i], 0, cyc, res, ds, ra);
         n_checks += 2;
         if (res !== vexp[i]) begin
            n_fail++; $display("FAIL boundary_%0d got ovf/cout/sum=%h want %h", i, res, vexp[i]);
         end
         if (cyc !== W || ds !== 1'b1) begin
            n_fail++; $display("FAIL boundary_%0d_timing got cyc=%0d done=%b want %0d/1", i, cyc, ds, W);
         end
      end
   endtask

   task automatic test_start_while_busy;
      int cyc;
      logic extra_busy;
      a_i = 8'h3C; b_i = 8'h42; cin_i = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (busy && cyc < LIMIT) begin
         cyc++;
         if (cyc == 3) begin
            a_i = 8'h11; b_i = 8'h22; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      n_checks += 2;
      if (cyc !== W) begin n_fail++; $display("FAIL ignore_start_latency got %0d want %0d", cyc, W); end
      if (done !== 1'b1 || sum !== 8'h7E) begin
         n_fail++; $display("FAIL ignore_start_result got done=%b sum=%h want 1/7e", done, sum);
      end
      done_ack = 1'b1;
      @(negedge clk);
      done_ack = 1'b0;
      extra_busy = 1'b0;
      repeat (3) begin
         if (busy || !ready) extra_busy = 1'b1;
         @(negedge clk);
      end
      n_checks++;
      if (extra_busy !== 1'b0) begin
         n_fail++; $display("FAIL ignore_start_no_extra_run got %b want 0", extra_busy);
      end
   endtask

   task automatic test_done_hold;
      int         cyc;
      logic       moved;
      logic [W+1:0] res;
      logic       ds, ra;
      a_i = 8'h3C; b_i = 8'h42; cin_i = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < LIMIT) begin cyc++; @(negedge clk); end
      moved = 1'b0;
      repeat (20) begin
         if (done !== 1'b1 || sum !== 8'h7E || cout !== 1'b0) moved = 1'b1;
         @(negedge clk);
      end
      n_checks++;
      if (moved !== 1'b0) begin n_fail++; $display("FAIL done_hold changed got %b want 0", moved); end
      // start together with done_ack must only return to idle
      a_i = 8'h11; b_i = 8'h22; start = 1'b1; done_ack = 1'b1;
      @(negedge clk);
      start = 1'b0; done_ack = 1'b0;
      n_checks++;
      if (ready !== 1'b1 || busy !== 1'b0 || sum !== 8'h7E) begin
         n_fail++; $display("FAIL start_with_ack got ready=%b busy=%b sum=%h want 1/0/7e", ready, busy, sum);
      end
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL start_with_ack_idle got ready=%b busy=%b want 1/0", ready, busy);
      end
      run_op(8'h11, 8'h22, 1'b0, 1, cyc, res, ds, ra);
      n_checks++;
      if (res !== {2'b00, 8'h33} || cyc !== W) begin
         n_fail++; $display("FAIL after_ack_add got res=%h cyc=%0d want 033/%0d", res, cyc, W);
      end
   endtask

   task automatic test_reset_mid_run;
      int         cyc;
      logic [W+1:0] res;
      logic       ds, ra;
      a_i = 8'h3C; b_i = 8'h42; cin_i = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      n_checks++;
      if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset got ready=%b busy=%b done=%b sum=%h cout=%b ovf=%b want 1/0/0/00/0/0",
                  ready, busy, done, sum, cout, ovf);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(8'h01, 8'h01, 1'b0, 0, cyc, res, ds, ra);
      n_checks++;
      if (res !== {2'b00, 8'h02} || cyc !== W) begin
         n_fail++; $display("FAIL post_reset_add got res=%h cyc=%0d want 002/%0d", res, cyc, W);
      end
   endtask

   task automatic test_random;
      int         cyc;
      logic [W+1:0] res, exp_v;
      logic       ds, ra;
      logic [W-1:0] ra_op, rb_op;
      logic       rc;
      for (int i = 0; i < 1000; i++) begin
         ra_op = W'($urandom);
         rb_op = W'($urandom);
         rc    = 1'($urandom);
         exp_q.push_back(model(ra_op, rb_op, rc));
         run_op(ra_op, rb_op, rc, $urandom_range(0, 5), cyc, res, ds, ra);
         exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         n_checks += 3;
         if (res !== exp_v) begin
            n_fail++;
            $display("FAIL rand_%0d result %h+%h+%b got ovf/cout/sum=%h want %h", i, ra_op, rb_op, rc, res, exp_v);
         end
         if (cyc !== W || ds !== 1'b1) begin
            n_fail++; $display("FAIL rand_%0d timing got cyc=%0d done=%b want %0d/1", i, cyc, ds, W);
         end
         if (ra !== 1'b1) begin n_fail++; $display("FAIL rand_%0d ready_after_ack got %b want 1", i, ra); end
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; done_ack = 1'b0;
      a_i = '0; b_i = '0; cin_i = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic_add();
      test_boundaries();
      test_start_while_busy();
      test_done_hold();
      test_reset_mid_run();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller that reuses one 1-bit full-adder slice (sum and carry) to add two WIDTH-bit operands over WIDTH clock cycles. It latches the operands on a start handshake, steps the slice through bit 0 to bit WIDTH-1 with a registered carry, and assembles the result in a shift register. It presents sum, carry-out and signed overflow until the consumer acknowledges, and trades area for latency in the arithmetic labs.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32

Ports:
clk      input   1      system clock, rising-edge active
rst_n    input   1      asynchronous active-low reset
start    input   1      request to begin an addition; sampled only when ready=1
a        input   WIDTH  operand A, captured on accepted start
b        input   WIDTH  operand B, captured on accepted start
cin      input   1      carry-in, captured on accepted start
ready    output  1      controller idle, start will be accepted
busy     output  1      addition in progress
done     output  1      result valid; held until done_ack
done_ack input   1      consumer acknowledge of result
sum      output  WIDTH  result bits
cout     output  1      carry out of bit WIDTH-1
ovf      output  1      signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Clocking and reset:
  - One clock domain.
  - rst_n low asynchronously forces: state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0, ovf=0, bit counter=0, carry reg=0, operand shift regs=0.
  - Reset release takes effect at the next rising clk edge.
  - Reset mid-RUN or mid-DONE aborts the operation and discards the result.
- FSM states: IDLE, RUN, DONE. Outputs are decoded from state: ready=(IDLE), busy=(RUN), done=(DONE).
- IDLE:
  - On an edge with start=1, load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, and go to RUN.
  - sum/cout/ovf keep their previous values until the new result completes.
  - With start=0, remain in IDLE.
- RUN: each edge processes one bit using the single slice.
  - s = a_sh[0] ^ b_sh[0] ^ carry.
  - c = majority(a_sh[0], b_sh[0], carry).
  - sum_sh <= {s, sum_sh[WIDTH-1:1]}.
  - a_sh and b_sh shift right by 1.
  - carry <= c.
  - cnt <= cnt+1.
  - When cnt == WIDTH-2, also record cmsb <= c (carry into MSB).
  - When cnt == WIDTH-1 (MSB processed):
    - sum <= final shifted value.
    - cout <= c.
    - ovf <= cmsb ^ c.
    - Go to DONE.
- Latency: start accepted at edge k → busy high from edge k through edge k+WIDTH-1 → done high after edge k+WIDTH. That is exactly WIDTH cycles in RUN.
- start is ignored while busy or done (ready=0). Operands may change freely after acceptance.
- DONE:
  - sum, cout and ovf are stable.
  - done_ack=1 on an edge → IDLE, with outputs retained.
  - done_ack is ignored in IDLE and RUN.
  - start asserted in DONE is not accepted; it is accepted earliest on the first edge after returning to IDLE. Minimum issue interval is WIDTH+2 cycles.
- Counter width is clog2(WIDTH). cnt never wraps within an operation; it is reloaded to 0 on every accepted start.
- No combinational path from any input to any output.

Test Plan:
1. WIDTH=8, reset then start with a=0x3C, b=0x42, cin=0 → busy for exactly 8 cycles; then done=1, sum=0x7E, cout=0, ovf=0; done_ack → ready=1.
2. a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0, ovf=1. Then a=0x80, b=0x80, cin=1 → sum=0x01, cout=1, ovf=1.
3. Pulse start with a=0x11, b=0x22 at cycle 3 of a running 0x3C+0x42 → the second start is ignored; result stays 0x7E; no extra busy period.
4. Hold done_ack=0 for 20 cycles after done → done, sum and cout stay constant. Assert start and done_ack together → return to IDLE only; the addition begins on the next start.
5. Assert rst_n low asynchronously (between clk edges) at RUN cycle 4 → all outputs 0 and ready=1 immediately. After release, a new a=0x01, b=0x01 gives sum=0x02 in 8 cycles.
6. Randomized 1000 operand/cin triples checked against a golden A+B+cin model, with random done_ack delay 0..5 cycles and random start gaps.
